// File: rtl/saliency_pkg.sv
// Shared definitions for the saliency pipeline front end: pixel width, token count
// constant and the horizontal smoother's state encoding.
package saliency_pkg;

    localparam int PIX_W = 16;
    localparam logic [15:0] TOK_ONE = 16'h1;

    typedef enum logic {
        S_EVEN = 1'b0,
        S_ODD  = 1'b1
    } hsd_state_t;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hsd_pos_counter.sv
// Column/row position of the accepted input pixel, with wrap flags for the last
// pixel of a line and of a frame.
module hsd_pos_counter
    import saliency_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         advance,
    output logic [cnt_w(IMG_WIDTH)-1:0]  col,
    output logic [cnt_w(IMG_HEIGHT)-1:0] row,
    output logic                         line_last,
    output logic                         frame_last
);

    localparam int COL_W = cnt_w(IMG_WIDTH);
    localparam int ROW_W = cnt_w(IMG_HEIGHT);

    assign line_last  = (col == COL_W'(IMG_WIDTH - 1));
    assign frame_last = line_last && (row == ROW_W'(IMG_HEIGHT - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (line_last) begin
                col <= '0;
                row <= frame_last ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/hh2_hsmooth_decim.sv
// Horizontal [1 2 1]/4 low-pass with 2:1 column decimation; one token out per
// accepted odd pixel, emitted in the same cycle the odd pixel is taken.
module hh2_hsmooth_decim
    import saliency_pkg::*;
#(
    parameter int DATA_W     = PIX_W,
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] In1_DATA,
    input  logic              In1_SEND,
    input  logic [15:0]       In1_COUNT,
    output logic              In1_ACK,
    output logic [DATA_W-1:0] Out1_DATA,
    output logic              Out1_SEND,
    output logic [15:0]       Out1_COUNT,
    input  logic              Out1_RDY,
    input  logic              Out1_ACK,
    output logic              frame_end,
    output hsd_state_t        fsm_state
);

    localparam int COL_W = cnt_w(IMG_WIDTH);
    localparam int ROW_W = cnt_w(IMG_HEIGHT);
    localparam int SW    = DATA_W + 2;

    hsd_state_t        state, state_next;
    logic [DATA_W-1:0] even_px, prev_odd, left, rounded;
    logic [SW-1:0]     sum;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              line_last, frame_last, fire_odd;
    logic              unused_ok;

    // Handshake: a token moves on In1 when In1_SEND and In1_ACK are both high in a
    // cycle; an odd pixel is only taken when Out1_RDY lets its token leave at once.
    always_comb begin
        state_next = state;
        In1_ACK    = 1'b0;
        fire_odd   = 1'b0;
        case (state)
            S_EVEN: begin
                In1_ACK = In1_SEND;
                if (In1_SEND) state_next = S_ODD;
            end
            S_ODD: begin
                In1_ACK  = In1_SEND & Out1_RDY;
                fire_odd = In1_SEND & Out1_RDY;
                if (fire_odd) state_next = S_EVEN;
            end
            default: state_next = S_EVEN;
        endcase
        if (RESET) begin
            In1_ACK  = 1'b0;
            fire_odd = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_EVEN;
            even_px  <= '0;
            prev_odd <= '0;
        end else begin
            state <= state_next;
            if (state == S_EVEN && In1_ACK) even_px <= In1_DATA;
            if (fire_odd) prev_odd <= In1_DATA;
        end
    end

    hsd_pos_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT)
    ) u_pos (
        .CLK       (CLK),
        .RESET     (RESET),
        .advance   (In1_ACK),
        .col       (col),
        .row       (row),
        .line_last (line_last),
        .frame_last(frame_last)
    );

    // col==1 marks the first pair of a line: replicate p[0] as its left neighbour.
    assign left    = (col == COL_W'(1)) ? even_px : prev_odd;
    assign sum     = SW'(left) + (SW'(even_px) << 1) + SW'(In1_DATA) + SW'(2);
    assign rounded = DATA_W'(sum >> 2);

    assign Out1_SEND  = fire_odd;
    assign Out1_DATA  = fire_odd ? rounded : '0;
    assign Out1_COUNT = fire_odd ? TOK_ONE : 16'h0;
    assign frame_end  = fire_odd & frame_last;
    assign fsm_state  = state;

    assign unused_ok = ^{In1_COUNT, Out1_ACK, line_last, row};

endmodule

// File: tb/tb_hh2_hsmooth_decim.sv
// Bench for hh2_hsmooth_decim: two instances (4x1 and 4x2 frames) share one input
// stream; a line-buffer reference model checks every cycle, plus directed tables.
module tb_hh2_hsmooth_decim;
    import saliency_pkg::*;

    localparam int DW = 16;
    localparam int W  = 4;
    localparam int HA = 1;
    localparam int HB = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] in_data = '0;
    logic          in_send = 1'b0;
    logic          out_rdy = 1'b1;
    logic [15:0]   in_count = 16'h1;
    logic          dn_ack = 1'b0;

    logic a_ack, a_send, a_fe, b_ack, b_send, b_fe;
    logic [DW-1:0] a_data, b_data;
    logic [15:0]   a_count, b_count;
    hsd_state_t    a_state, b_state;

    hh2_hsmooth_decim #(.DATA_W(DW), .IMG_WIDTH(W), .IMG_HEIGHT(HA)) dut_a (
        .CLK(clk), .RESET(reset), .In1_DATA(in_data), .In1_SEND(in_send),
        .In1_COUNT(in_count), .In1_ACK(a_ack), .Out1_DATA(a_data), .Out1_SEND(a_send),
        .Out1_COUNT(a_count), .Out1_RDY(out_rdy), .Out1_ACK(dn_ack),
        .frame_end(a_fe), .fsm_state(a_state)
    );

    hh2_hsmooth_decim #(.DATA_W(DW), .IMG_WIDTH(W), .IMG_HEIGHT(HB)) dut_b (
        .CLK(clk), .RESET(reset), .In1_DATA(in_data), .In1_SEND(in_send),
        .In1_COUNT(in_count), .In1_ACK(b_ack), .Out1_DATA(b_data), .Out1_SEND(b_send),
        .Out1_COUNT(b_count), .Out1_RDY(out_rdy), .Out1_ACK(dn_ack),
        .frame_end(b_fe), .fsm_state(b_state)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    // n counts pixels accepted since reset; line_px holds the current input line.
    int            n = 0;
    logic [DW-1:0] line_px [W];
    logic [DW:0]   got_q [$];
    logic [DW:0]   exp_q [$];
    int            a_fe_cnt = 0, b_tok = 0, b_fe_cnt = 0;

    always @(negedge clk) begin
        int c, s, lft;
        logic exp_ack, exp_fire;
        logic [DW-1:0] exp_data;
        if (reset) begin
            check("rst_a_ack", a_ack, 0);     check("rst_a_send", a_send, 0);
            check("rst_a_data", a_data, 0);   check("rst_a_count", a_count, 0);
            check("rst_a_fe", a_fe, 0);       check("rst_b_ack", b_ack, 0);
            check("rst_b_send", b_send, 0);   check("rst_b_fe", b_fe, 0);
            n = 0;
        end else begin
            c        = n % W;
            exp_ack  = in_send && ((n % 2 == 0) || out_rdy);
            exp_fire = exp_ack && (n % 2 == 1);
            exp_data = '0;
            if (exp_fire) begin
                if (c == 1) lft = int'(line_px[0]);
                else        lft = int'(line_px[c-2]);
                s = lft + 2 * int'(line_px[c-1]) + int'(in_data) + 2;
                exp_data = DW'(s / 4);
            end
            check("a_ack", a_ack, exp_ack);       check("b_ack", b_ack, exp_ack);
            check("a_send", a_send, exp_fire);    check("b_send", b_send, exp_fire);
            check("a_data", a_data, exp_data);    check("b_data", b_data, exp_data);
            check("a_count", a_count, exp_fire ? 1 : 0);
            check("b_count", b_count, exp_fire ? 1 : 0);
            check("a_frame_end", a_fe, exp_fire && (n % (W*HA) == W*HA - 1));
            check("b_frame_end", b_fe, exp_fire && (n % (W*HB) == W*HB - 1));
            if (exp_ack) begin
                line_px[c] = in_data;
                n++;
            end
        end
        if (a_send) got_q.push_back({a_fe, a_data});
        if (a_fe) a_fe_cnt++;
        if (b_send) b_tok++;
        if (b_fe) b_fe_cnt++;
    end

    // ---------------- driver tasks ----------------
    bit rdy_rand = 1'b0;
    always begin
        @(posedge clk); #1;
        if (rdy_rand) out_rdy = 1'($urandom_range(0, 1));
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push_px(input logic [DW-1:0] d, input int max_gap);
        int k;
        bit done;
        repeat ($urandom_range(0, max_gap)) step();
        in_send = 1'b1;
        in_data = d;
        done = 1'b0;
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            done = (a_ack === 1'b1);
            k++;
            step();
        end
        if (!done) check("push_timeout", done, 1);
        in_send = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) step();
        reset = 1'b0;
    endtask

    // ---------------- directed tables ----------------
    typedef struct {
        logic [DW-1:0] px [4];
        logic [DW-1:0] exp0;
        logic [DW-1:0] exp1;
    } vec_t;
    vec_t tbl [5];

    initial begin
        logic [DW:0] g, e;
        int tok0, fe0;
        tbl[0].px = '{16'd10, 16'd20, 16'd30, 16'd40};         tbl[0].exp0 = 16'd13;     tbl[0].exp1 = 16'd30;
        tbl[1].px = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}; tbl[1].exp0 = 16'hFFFF;   tbl[1].exp1 = 16'hFFFF;
        tbl[2].px = '{16'd0, 16'd0, 16'd0, 16'd0};             tbl[2].exp0 = 16'd0;      tbl[2].exp1 = 16'd0;
        tbl[3].px = '{16'd1, 16'd2, 16'd3, 16'd4};             tbl[3].exp0 = 16'd1;      tbl[3].exp1 = 16'd3;
        tbl[4].px = '{16'd100, 16'd0, 16'd0, 16'd100};         tbl[4].exp0 = 16'd75;     tbl[4].exp1 = 16'd25;

        do_reset(2);

        // Reset mid-line with a pending pixel offered: nothing may be taken or sent.
        push_px(16'd7, 0); push_px(16'd8, 0); push_px(16'd9, 0);
        reset = 1'b1;
        in_send = 1'b1;
        in_data = 16'd55;
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_ack", a_ack, 0);
            check("mid_rst_send", a_send, 0);
            step();
        end
        reset = 1'b0;
        in_send = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("idle_send", a_send, 0);
            check("idle_data", a_data, 0);
            check("idle_state", a_state, S_EVEN);
            step();
        end
        got_q.delete();

        // Table: each row is one full 4x1 frame on dut_a.
        for (int r = 0; r < 5; r++) begin
            exp_q.push_back({1'b0, tbl[r].exp0});
            exp_q.push_back({1'b1, tbl[r].exp1});
            for (int i = 0; i < 4; i++) push_px(tbl[r].px[i], 0);
            step();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (got_q.size() == 0) begin
                    check("tbl_missing_token", 0, 1);
                end else begin
                    g = got_q.pop_front();
                    check("tbl_token", g, e);
                end
            end
            check("tbl_extra_tokens", got_q.size(), 0);
        end

        // Backpressure on the odd pixel for five cycles, then release.
        do_reset(2);
        push_px(16'd50, 0);
        out_rdy = 1'b0;
        in_send = 1'b1;
        in_data = 16'd70;
        repeat (5) begin
            @(negedge clk);
            check("bp_ack", a_ack, 0);
            check("bp_send", a_send, 0);
            step();
        end
        out_rdy = 1'b1;
        @(negedge clk);
        check("bp_release_send", a_send, 1);
        check("bp_release_data", a_data, 16'd55);
        step();
        in_send = 1'b0;
        push_px(16'd90, 0);
        push_px(16'd110, 0);

        // Frame wrap on the 4x2 instance: two frames back to back.
        do_reset(2);
        tok0 = b_tok;
        fe0  = b_fe_cnt;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 8; i++) push_px(DW'(i * 37 + 5), 0);
        step();
        check("wrap_tokens", b_tok - tok0, 8);
        check("wrap_frame_ends", b_fe_cnt - fe0, 2);

        // Random data, input bubbles and downstream stalls.
        do_reset(2);
        tok0 = b_tok;
        fe0  = b_fe_cnt;
        rdy_rand = 1'b1;
        for (int i = 0; i < 48; i++) push_px(DW'($urandom), 2);
        rdy_rand = 1'b0;
        out_rdy = 1'b1;
        step();
        check("rand_tokens", b_tok - tok0, 24);
        check("rand_frame_ends", b_fe_cnt - fe0, 6);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
